// File: rtl/i2c_pkg.sv
// Shared I2C definitions: idle bus level, default conditioner depths and the
// strobe bundle passed from the bus conditioner to the target.
package i2c_pkg;

   localparam logic I2C_IDLE_LEVEL        = 1'b1;
   localparam int   I2C_SYNC_STAGES_DEF   = 2;
   localparam int   I2C_FILTER_CYCLES_DEF = 3;

   typedef struct packed {
      logic scl_rise;
      logic scl_fall;
      logic start;
      logic stop;
   } i2c_bus_ev_t;

endpackage

// File: rtl/i2c_line_filter.sv
// One I2C line: pad synchroniser followed by a stability filter. The next
// filtered level is exported so the parent can register edge strobes in step.
module i2c_line_filter
   import i2c_pkg::*;
#(
   parameter int SYNC_STAGES   = I2C_SYNC_STAGES_DEF,
   parameter int FILTER_CYCLES = I2C_FILTER_CYCLES_DEF
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic line_i,
   output logic level_next_o
);

   localparam int              CNT_W    = $clog2(FILTER_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   sync_line_s;
   logic                   filt_q;
   logic                   filt_d;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;

   assign sync_line_s  = sync_q[SYNC_STAGES-1];
   assign level_next_o = filt_d;

   // Shift the raw pad level into the synchroniser chain.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], line_i};
   end

   // Count consecutive disagreeing samples; commit the new level on the last one.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = CNT_ZERO;
      if (sync_line_s == filt_q) begin
         cnt_d = CNT_ZERO;
      end else if (cnt_q >= CNT_LAST) begin
         filt_d = sync_line_s;
         cnt_d  = CNT_ZERO;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // State registers; the bus is idle-high out of reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= {SYNC_STAGES{I2C_IDLE_LEVEL}};
         filt_q <= I2C_IDLE_LEVEL;
         cnt_q  <= CNT_ZERO;
      end else begin
         sync_q <= sync_d;
         filt_q <= filt_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/i2c_bus_conditioner.sv
// Pad front-end for i2c_target: filtered SCL/SDA levels, SCL edge strobes,
// START/STOP strobes and a bus-busy flag, all driven from flops.
module i2c_bus_conditioner
   import i2c_pkg::*;
#(
   parameter int SYNC_STAGES   = I2C_SYNC_STAGES_DEF,
   parameter int FILTER_CYCLES = I2C_FILTER_CYCLES_DEF
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_o,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o,
   output logic busy_o
);

   logic        scl_next_s;
   logic        sda_next_s;
   logic        scl_q;
   logic        sda_q;
   logic        scl_d;
   logic        sda_d;
   i2c_bus_ev_t ev_q;
   i2c_bus_ev_t ev_d;
   logic        busy_q;
   logic        busy_d;

   i2c_line_filter #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES)
   ) u_scl_filter (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .line_i       (scl_i),
      .level_next_o (scl_next_s)
   );

   i2c_line_filter #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES)
   ) u_sda_filter (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .line_i       (sda_i),
      .level_next_o (sda_next_s)
   );

   // Strobes compare the committed level with the level about to be committed,
   // so they land in the same cycle the filtered output changes.
   always_comb begin
      scl_d          = scl_next_s;
      sda_d          = sda_next_s;
      ev_d.scl_rise  = scl_next_s & ~scl_q;
      ev_d.scl_fall  = ~scl_next_s & scl_q;
      ev_d.start     = sda_q & ~sda_next_s & scl_q & scl_next_s;
      ev_d.stop      = ~sda_q & sda_next_s & scl_q & scl_next_s;
   end

   // Busy follows the registered START/STOP strobes one cycle later.
   always_comb begin
      busy_d = busy_q;
      if (ev_q.start) begin
         busy_d = 1'b1;
      end else if (ev_q.stop) begin
         busy_d = 1'b0;
      end else begin
         busy_d = busy_q;
      end
   end

   // Output and event registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         scl_q  <= I2C_IDLE_LEVEL;
         sda_q  <= I2C_IDLE_LEVEL;
         ev_q   <= '{scl_rise: 1'b0, scl_fall: 1'b0, start: 1'b0, stop: 1'b0};
         busy_q <= 1'b0;
      end else begin
         scl_q  <= scl_d;
         sda_q  <= sda_d;
         ev_q   <= ev_d;
         busy_q <= busy_d;
      end
   end

   assign scl_o      = scl_q;
   assign sda_o      = sda_q;
   assign scl_rise_o = ev_q.scl_rise;
   assign scl_fall_o = ev_q.scl_fall;
   assign start_o    = ev_q.start;
   assign stop_o     = ev_q.stop;
   assign busy_o     = busy_q;

endmodule

// File: doc/i2c_bus_conditioner.md
# i2c_bus_conditioner

Front-end stage between the raw I2C pads and `i2c_target`. It synchronises the asynchronous SCL and SDA pad inputs into `clk_i`, rejects glitches shorter than a programmable number of cycles, and produces clean line levels. It also produces one-cycle SCL edge, START and STOP strobes and a bus-busy flag, which `i2c_target` consumes instead of sampling pads directly.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser depth per line. Legal range ≥ 2.
- `FILTER_CYCLES`, default 3: consecutive stable cycles required before a filtered level changes. Legal range ≥ 1.

Ports:
- `clk_i` input, 1 bit: system clock. There is one clock only.
- `rst_ni` input, 1 bit: reset, asynchronous and active-low.
- `scl_i` input, 1 bit: raw SCL pad level.
- `sda_i` input, 1 bit: raw SDA pad level. This is the input half of the `sda_io` pad.
- `scl_o` output, 1 bit: filtered SCL level.
- `sda_o` output, 1 bit: filtered SDA level.
- `scl_rise_o` output, 1 bit: one-cycle strobe on a filtered SCL 0→1 transition.
- `scl_fall_o` output, 1 bit: one-cycle strobe on a filtered SCL 1→0 transition.
- `start_o` output, 1 bit: one-cycle strobe for a START or repeated START.
- `stop_o` output, 1 bit: one-cycle strobe for a STOP.
- `busy_o` output, 1 bit: high between a START and the following STOP.

## Operation
- **Synchroniser.** Each line has a `SYNC_STAGES`-deep flop chain. All stages reset to 1 (idle bus).
- **Line filter.** Each line has a counter of width `$clog2(FILTER_CYCLES+1)` that tracks the synchronised value against the filtered value.
  - Sync equals filtered: counter cleared to 0.
  - Sync differs from filtered: counter increments.
  - When the increment would reach `FILTER_CYCLES`, the filtered value takes the sync value and the counter clears in the same edge.
  - The counter never wraps.
- **Edge strobes.** They are registered and asserted in the same cycle that `scl_o` first shows its new value.
- **START.** Filtered SDA goes 1→0 while filtered SCL is 1 both before and after that edge.
- **STOP.** Filtered SDA goes 0→1 under the same SCL condition.
- **Simultaneous change.** If filtered SDA and SCL change on the same edge, `start_o` and `stop_o` stay 0. Only the SCL strobe fires.
- **busy_o.**
  - Set on `start_o`, cleared on `stop_o`.
  - A repeated START while busy pulses `start_o` and `busy_o` stays 1.
  - A STOP while not busy pulses `stop_o` and `busy_o` stays 0.
- **Reset values.**
  - `scl_o` and `sda_o` are 1.
  - `scl_rise_o`, `scl_fall_o`, `start_o`, `stop_o` and `busy_o` are 0.
  - Filter counters are 0.
- **Reset mid-operation.** Asserting `rst_ni` forces all of the above immediately. A partially counted glitch or an in-flight transfer is discarded; there is no residual strobe after release.

## Timing
- **Latency.** A raw level change held stable is visible on `scl_o`/`sda_o` at the (`SYNC_STAGES` + `FILTER_CYCLES`)-th rising edge, counting the first capturing edge as 1. With defaults this is edge 5.
- **Strobe alignment.** All strobes are asserted in that same cycle and last exactly one cycle.
- **Glitch rejection.**
  - A raw pulse stable for ≤ `FILTER_CYCLES`−1 sampled cycles never reaches the outputs.
  - A pulse stable for ≥ `FILTER_CYCLES` cycles always propagates.
- **Back-to-back transitions.** Consecutive filtered transitions on one line are at least `FILTER_CYCLES` cycles apart.
- **Outputs.** All outputs are driven directly from flops, with no combinational path from pads.

## Structure
- **Shared package `i2c_pkg`:**
  - `I2C_IDLE_LEVEL` = 1'b1.
  - Default `SYNC_STAGES` and `FILTER_CYCLES`.
  - Strobe-bundle typedef `i2c_bus_ev_t` with fields scl_rise, scl_fall, start, stop.
- **Sub-module `i2c_line_filter`.** It contains the synchroniser plus the filter counter for one line, is parameterised identically, and is instantiated twice (SCL, SDA). The top of this block holds the previous-value flops, strobe generation and the busy flag.

## Test plan
- **Glitch.** Idle bus, pulse `sda_i` low for 2 cycles (FILTER_CYCLES=3) → `sda_o` stays 1 and no strobes. Then hold it low for 3 cycles → `sda_o` falls at edge 5.
- **START.** With `scl_i`=1, drive `sda_i` 1→0 → at edge 5 `sda_o`=0, `start_o`=1 for 1 cycle, `busy_o`=1 from the next cycle.
- **Clocked bit then STOP.**
  - Toggle `scl_i` with period 20 cycles → `scl_fall_o`/`scl_rise_o` pulse once per edge, with `start_o`/`stop_o` silent while SDA is stable.
  - Then, with SCL high, drive SDA 0→1 → `stop_o`=1 and `busy_o`=0.
- **Repeated START.** While busy, perform SCL high, then SDA 1→0 → `start_o` pulses and `busy_o` remains 1 throughout.
- **Simultaneous change.** Change `scl_i` and `sda_i` on the same raw edge → `scl_*` strobe only, `start_o`=`stop_o`=0.
- **Reset mid-operation.** Assert `rst_ni` while busy and with a filter count at 2 → outputs are immediately 1/1/0 and `busy_o`=0. After release, with pads idle, no strobes occur for 10 cycles.
